commutation_sequencer: RTL and testbench

COMMUTATION_SEQUENCER -- requirements
Module: commutation_sequencer

---
 rtl/commutation_sequencer_if.sv | 28 ++
 rtl/commutation_sequencer.sv | 167 ++++++++++++++++
 tb/tb_commutation_sequencer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/commutation_sequencer_if.sv
// Bundle of hall inputs, duty/enable/direction controls and gate/status outputs
// of the BLDC commutation sequencer.
interface commutation_sequencer_if;
    logic       h1;
    logic       h2;
    logic       h3;
    logic [3:0] d;
    logic       en;
    logic       dir;
    logic       a;
    logic       b;
    logic       c;
    logic       aa;
    logic       bb;
    logic       cc;
    logic       fault;
    logic [1:0] state;

    modport master (
        output h1, h2, h3, d, en, dir,
        input  a, b, c, aa, bb, cc, fault, state
    );

    modport slave (
        input  h1, h2, h3, d, en, dir,
        output a, b, c, aa, bb, cc, fault, state
    );
endinterface

// File: rtl/commutation_sequencer.sv
// Six-step BLDC commutation sequencer: hall synchronizer and stability filter,
// PWM on the selected high-side gate, dead-time on every commutation, stall and
// invalid-code fault detection.
module commutation_sequencer #(
    parameter int unsigned FILT      = 3,
    parameter int unsigned DEAD      = 2,
    parameter int unsigned STALL_MAX = 4095
) (
    input logic                    clk,
    input logic                    rst,
    commutation_sequencer_if.slave bus
);

    localparam int unsigned       FW       = (FILT > 1) ? $clog2(FILT + 1) : 1;
    localparam logic [FW-1:0]     FiltCnt  = FW'(FILT);
    localparam logic [3:0]        DeadLoad = 4'(DEAD - 1);
    localparam logic [11:0]       StallMax = 12'(STALL_MAX);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDead  = 2'd1,
        StRun   = 2'd2,
        StFault = 2'd3
    } state_e;

    logic [2:0]    sync1_q, sync2_q, cand_q, hq_q, hq_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic [3:0]    pc_q, pc_d;
    logic [3:0]    dead_cnt_q;
    logic [11:0]   stall_q;
    logic [2:0]    run_hq_q;
    logic          run_dir_q;
    state_e        state_q;
    logic [2:0]    hi_q, lo_q;      // phase masks, bit 0 = A, bit 1 = B, bit 2 = C
    logic          fault_q;

    logic [2:0]    fwd_hi, fwd_lo, sel_hi, sel_lo;
    logic          hq_valid, pwm_on;

    // Stability filter: count consecutive identical synchronized codes
    always_comb begin
        filt_cnt_d = filt_cnt_q;
        hq_d       = hq_q;
        if (sync2_q != cand_q) begin
            filt_cnt_d = FW'(1);
        end else if (filt_cnt_q != FiltCnt) begin
            filt_cnt_d = filt_cnt_q + FW'(1);
        end
        if (filt_cnt_d == FiltCnt) begin
            hq_d = sync2_q;
        end
    end

    // Commutation table lookup, direction swap and PWM compare
    always_comb begin
        fwd_hi = 3'b000;
        fwd_lo = 3'b000;
        case (hq_q)
            3'b101:  begin fwd_hi = 3'b001; fwd_lo = 3'b010; end
            3'b100:  begin fwd_hi = 3'b001; fwd_lo = 3'b100; end
            3'b110:  begin fwd_hi = 3'b010; fwd_lo = 3'b100; end
            3'b010:  begin fwd_hi = 3'b010; fwd_lo = 3'b001; end
            3'b011:  begin fwd_hi = 3'b100; fwd_lo = 3'b001; end
            3'b001:  begin fwd_hi = 3'b100; fwd_lo = 3'b010; end
            default: begin fwd_hi = 3'b000; fwd_lo = 3'b000; end
        endcase
        sel_hi   = bus.dir ? fwd_lo : fwd_hi;
        sel_lo   = bus.dir ? fwd_hi : fwd_lo;
        hq_valid = (hq_q != 3'b000) && (hq_q != 3'b111);
        pc_d     = pc_q + 4'd1;
        // Gates are registered, so compare against the PC value they will coincide with
        pwm_on   = pc_d < bus.d;
    end

    // Hall synchronizer, accepted hall code and free-running PWM counter
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 3'b000;
            sync2_q    <= 3'b000;
            cand_q     <= 3'b000;
            filt_cnt_q <= '0;
            hq_q       <= 3'b000;
            pc_q       <= 4'd0;
        end else begin
            sync1_q    <= {bus.h3, bus.h2, bus.h1};
            sync2_q    <= sync1_q;
            cand_q     <= sync2_q;
            filt_cnt_q <= filt_cnt_d;
            hq_q       <= hq_d;
            pc_q       <= pc_d;
        end
    end

    // Sequencer FSM with registered gate drives and fault flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            hi_q       <= 3'b000;
            lo_q       <= 3'b000;
            fault_q    <= 1'b0;
            stall_q    <= 12'd0;
            dead_cnt_q <= 4'd0;
            run_hq_q   <= 3'b000;
            run_dir_q  <= 1'b0;
        end else begin
            hi_q    <= 3'b000;
            lo_q    <= 3'b000;
            stall_q <= 12'd0;
            if (!bus.en) begin
                state_q <= StIdle;
                fault_q <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (hq_valid) begin
                            state_q    <= StDead;
                            dead_cnt_q <= DeadLoad;
                        end
                    end
                    StDead: begin
                        if (!hq_valid) begin
                            state_q <= StFault;
                            fault_q <= 1'b1;
                        end else if (dead_cnt_q == 4'd0) begin
                            state_q   <= StRun;
                            hi_q      <= pwm_on ? sel_hi : 3'b000;
                            lo_q      <= sel_lo;
                            run_hq_q  <= hq_q;
                            run_dir_q <= bus.dir;
                        end else begin
                            dead_cnt_q <= dead_cnt_q - 4'd1;
                        end
                    end
                    StRun: begin
                        if (!hq_valid) begin
                            state_q <= StFault;
                            fault_q <= 1'b1;
                        end else if (hq_q != run_hq_q || bus.dir != run_dir_q) begin
                            state_q    <= StDead;
                            dead_cnt_q <= DeadLoad;
                        end else if (stall_q + 12'd1 == StallMax) begin
                            state_q <= StFault;
                            fault_q <= 1'b1;
                        end else begin
                            hi_q    <= pwm_on ? sel_hi : 3'b000;
                            lo_q    <= sel_lo;
                            stall_q <= stall_q + 12'd1;
                        end
                    end
                    StFault: begin
                        state_q <= StFault;
                    end
                endcase
            end
        end
    end

    assign bus.a     = hi_q[0];
    assign bus.b     = hi_q[1];
    assign bus.c     = hi_q[2];
    assign bus.aa    = lo_q[0];
    assign bus.bb    = lo_q[1];
    assign bus.cc    = lo_q[2];
    assign bus.fault = fault_q;
    assign bus.state = state_q;

endmodule

// File: tb/tb_commutation_sequencer.sv
// Scoreboard bench for commutation_sequencer: stimulus pushes per-cycle expected
// gate/fault/state values, a negedge monitor pops and compares them.
module tb_commutation_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    commutation_sequencer_if bus ();

    commutation_sequencer #(
        .FILT      (3),
        .DEAD      (2),
        .STALL_MAX (4095)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int         cyc;
        string      nm;
        logic [5:0] g;      // {a, b, c, aa, bb, cc}
        logic       f;
        logic [1:0] st;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         cyc = 0;
    logic [3:0] mpc = 4'd0;
    int         checks = 0;
    int         errors = 0;
    logic       inv_on = 1'b0;

    // Cycle counter and reference PWM counter
    always @(posedge clk) begin
        cyc <= cyc + 1;
        mpc <= rst ? 4'd0 : mpc + 4'd1;
    end

    function automatic logic [5:0] pat(input logic [2:0] code, input logic dr, input logic on);
        logic [2:0] hi, lo, t;
        case (code)
            3'b101:  begin hi = 3'b100; lo = 3'b010; end
            3'b100:  begin hi = 3'b100; lo = 3'b001; end
            3'b110:  begin hi = 3'b010; lo = 3'b001; end
            3'b010:  begin hi = 3'b010; lo = 3'b100; end
            3'b011:  begin hi = 3'b001; lo = 3'b100; end
            3'b001:  begin hi = 3'b001; lo = 3'b010; end
            default: begin hi = 3'b000; lo = 3'b000; end
        endcase
        if (dr) begin
            t  = hi;
            hi = lo;
            lo = t;
        end
        return {on ? hi : 3'b000, lo};
    endfunction

    task automatic expect_at(input int t, input string nm, input logic [5:0] g, input logic f,
                             input logic [1:0] st);
        exp_t x;
        x.cyc = t;
        x.nm  = nm;
        x.g   = g;
        x.f   = f;
        x.st  = st;
        sb.push_back(x);
    endtask

    task automatic expect_off(input int t0, input int n, input string nm, input logic f,
                              input logic [1:0] st);
        for (int k = 0; k < n; k++) expect_at(t0 + k, nm, 6'b000000, f, st);
    endtask

    task automatic expect_run(input int t0, input int n, input string nm, input logic [2:0] code,
                              input logic dr, input logic [3:0] dd);
        for (int k = 0; k < n; k++) begin
            logic [3:0] p;
            p = 4'(int'(mpc) + t0 + k - cyc);
            expect_at(t0 + k, nm, pat(code, dr, p < dd), 1'b0, 2'd2);
        end
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_hall(input logic [2:0] h);
        bus.h3 = h[2];
        bus.h2 = h[1];
        bus.h1 = h[0];
    endtask

    // Monitor: gate invariant every cycle, scoreboard entries due this cycle
    always @(negedge clk) begin
        logic [5:0] g;
        g = {bus.a, bus.b, bus.c, bus.aa, bus.bb, bus.cc};
        if (inv_on) begin
            checks++;
            if ((g[5] & g[2]) | (g[4] & g[1]) | (g[3] & g[0]) | ($countones(g[5:3]) > 1) |
                ($countones(g[2:0]) > 1) | $isunknown(g)) begin
                errors++;
                $display("FAIL invariant cyc=%0d gates=%b", cyc, g);
            end
        end
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.cyc != cyc || g !== e.g || bus.fault !== e.f || bus.state !== e.st) begin
                errors++;
                $display("FAIL %s cyc=%0d due=%0d got gates=%b fault=%b state=%0d want gates=%b fault=%b state=%0d",
                         e.nm, cyc, e.cyc, g, bus.fault, bus.state, e.g, e.f, e.st);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p, r0, r1;
        bus.en  = 1'b1;
        bus.d   = 4'd8;
        bus.dir = 1'b0;
        set_hall(3'b000);
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        expect_off(cyc, 1, "reset", 1'b0, 2'd0);
        rst    = 1'b0;
        inv_on = 1'b1;
        expect_off(cyc + 6, 1, "idle_invalid", 1'b0, 2'd0);
        wait_to(cyc + 7);

        // Start-up on steady 101
        p = cyc;
        set_hall(3'b101);
        expect_off(p + 5, 1, "start_idle", 1'b0, 2'd0);
        expect_off(p + 6, 2, "start_dead", 1'b0, 2'd1);
        expect_run(p + 8, 32, "start_run", 3'b101, 1'b0, 4'd8);
        wait_to(p + 40);

        // Two-cycle glitch to 100 must not commutate
        p = cyc;
        expect_run(p, 24, "glitch", 3'b101, 1'b0, 4'd8);
        set_hall(3'b100);
        wait_to(p + 2);
        set_hall(3'b101);
        wait_to(p + 24);

        // Commutation 101 -> 100
        p = cyc;
        set_hall(3'b100);
        expect_run(p, 6, "pre_commut", 3'b101, 1'b0, 4'd8);
        expect_off(p + 6, 2, "commut_dead", 1'b0, 2'd1);
        expect_run(p + 8, 16, "commut_run", 3'b100, 1'b0, 4'd8);
        wait_to(p + 24);

        // Direction reversal
        p = cyc;
        bus.dir = 1'b1;
        expect_run(p, 1, "pre_dir", 3'b100, 1'b0, 4'd8);
        expect_off(p + 1, 2, "dir_dead", 1'b0, 2'd1);
        expect_run(p + 3, 16, "dir_run", 3'b100, 1'b1, 4'd8);
        wait_to(p + 19);

        // Duty extremes
        p = cyc;
        bus.d = 4'd15;
        expect_run(p + 1, 16, "duty15", 3'b100, 1'b1, 4'd15);
        wait_to(p + 17);
        p = cyc;
        bus.d = 4'd0;
        expect_run(p + 1, 16, "duty0", 3'b100, 1'b1, 4'd0);
        wait_to(p + 17);
        bus.d = 4'd8;
        wait_to(cyc + 1);

        // Invalid code 111 -> FAULT, cleared by EN=0
        p = cyc;
        set_hall(3'b111);
        expect_run(p, 6, "pre_fault", 3'b100, 1'b1, 4'd8);
        expect_off(p + 6, 5, "fault", 1'b1, 2'd3);
        wait_to(p + 11);
        p = cyc;
        bus.en = 1'b0;
        expect_off(p, 1, "fault_hold", 1'b1, 2'd3);
        expect_off(p + 1, 1, "fault_clear", 1'b0, 2'd0);
        wait_to(p + 3);

        // Stall: a change before the limit survives, then a full hold faults
        p = cyc;
        set_hall(3'b101);
        bus.dir = 1'b0;
        bus.en  = 1'b1;
        expect_off(p + 6, 2, "restart_dead", 1'b0, 2'd1);
        r0 = p + 8;
        expect_run(r0, 4, "restart_run", 3'b101, 1'b0, 4'd8);
        wait_to(r0 + 3990);
        set_hall(3'b100);
        expect_run(r0 + 3990, 6, "pre_stall_commut", 3'b101, 1'b0, 4'd8);
        expect_off(r0 + 3996, 2, "stall_commut_dead", 1'b0, 2'd1);
        r1 = r0 + 3998;
        expect_run(r1, 4, "stall_run", 3'b100, 1'b0, 4'd8);
        expect_run(r0 + 4100, 1, "no_stall_fault", 3'b100, 1'b0, 4'd8);
        expect_run(r1 + 4094, 1, "stall_last_run", 3'b100, 1'b0, 4'd8);
        expect_off(r1 + 4095, 1, "stall_fault", 1'b1, 2'd3);
        wait_to(r1 + 4097);

        // Re-enable, then reset mid-RUN
        bus.en = 1'b0;
        wait_to(cyc + 2);
        p = cyc;
        bus.en = 1'b1;
        expect_off(p + 1, 2, "reen_dead", 1'b0, 2'd1);
        expect_run(p + 3, 3, "reen_run", 3'b100, 1'b0, 4'd8);
        wait_to(p + 5);
        rst = 1'b1;
        expect_off(p + 6, 2, "reset_run", 1'b0, 2'd0);
        wait_to(p + 7);
        rst = 1'b0;
        wait_to(cyc + 3);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
